sifive_scope_tl_e_tracer: RTL
=============================

# sifive_scope_tl_e_tracer

Parametrised trace-capture block for a TileLink channel-E (GrantAck) probe point in the scope subsystem. It passively samples the monitored channel's `valid`/`ready`/`sink` signals and records each completed handshake (fire) with an optional timestamp into a circular buffer of configurable depth. It supports one-shot and wrap capture modes. Captured entries are drained through a valid/ready read port by the debug/scope readout logic.

## Interface
Parameters:
- `SINK_W`, 1, width of the monitored `sink` field (≥1)
- `DEPTH`, 8, buffer entries; power of two, ≥2
- `TS_W`, 16, timestamp width (≥1)
- `MODE`, 0, 0 = one-shot (stop when full), 1 = wrap (overwrite oldest)

Ports:
- `clock`  in  1  sole clock
- `reset_n`  in  1  asynchronous active-low reset
- `mon_valid`  in  1  monitored channel-E valid
- `mon_ready`  in  1  monitored channel-E ready
- `mon_sink`  in  SINK_W  monitored channel-E sink id
- `arm`  in  1  single-cycle pulse; flush buffer and start capture
- `stop`  in  1  single-cycle pulse; end capture
- `rd_valid`  out  1  buffer non-empty
- `rd_ready`  in  1  reader accepts head entry
- `rd_sink`  out  SINK_W  head entry sink
- `rd_ts`  out  TS_W  head entry timestamp
- `capturing`  out  1  state == CAPTURE
- `done`  out  1  state == DONE
- `count`  out  $clog2(DEPTH+1)  entries held
- `drop_cnt`  out  8  dropped/overwritten events, saturating at 255

## Operation
- fire = `mon_valid & mon_ready`. pop = `rd_valid & rd_ready`. The block never drives the monitored channel.
- States: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE on `arm`.
  - CAPTURE -> DONE on `stop`, or, when MODE=0, on the write that makes `count` reach DEPTH.
  - DONE -> CAPTURE on `arm`.
  - `stop` outside CAPTURE is ignored.
- `arm` in any state does all of the following next cycle:
  - resets read and write pointers, so `count`=0;
  - clears `drop_cnt` and the timestamp counter;
  - discards any same-cycle pop.
- Timestamp counter: TS_W bits. It increments each cycle in CAPTURE, wraps modulo 2^TS_W, and holds in IDLE and DONE.
- Capture: on fire in CAPTURE, the entry {`mon_sink`, timestamp} is written at the write pointer.
  - `count` < DEPTH: write, `count`+1.
  - `count` == DEPTH with same-cycle pop: write accepted; `count` unchanged.
  - `count` == DEPTH, no pop, MODE=0: cannot occur, because the block is already in DONE.
  - `count` == DEPTH, no pop, MODE=1: overwrite the oldest entry, advance the read pointer, `count` unchanged, `drop_cnt`+1.
- Fire in IDLE or DONE is not recorded and does not count as a drop.
- Readout works in every state. The head entry is presented from the storage array. A pop advances the read pointer.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are tracked by `count`.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream) forces:
  - state IDLE;
  - `rd_valid`, `capturing`, `done`, `count`, `drop_cnt`, timestamp and pointers all 0;
  - `rd_sink`/`rd_ts` 0 (storage cleared).
- Reset mid-capture discards all entries immediately.
- `arm` at cycle t: `capturing`=1 at t+1. A fire at t is not captured; a fire at t+1 is captured with ts=0.
- `stop` at cycle t: a fire at t is captured; `done`=1 at t+1.
- `arm` and `stop` in the same cycle: `arm` wins.
- Fire at cycle t into an empty buffer: `rd_valid`=1 at t+1 with that entry's data (latency 1).
- Pop at t: the next entry (or `rd_valid`=0) is visible at t+1.
- `rd_sink`/`rd_ts` are stable while `rd_valid` & !`rd_ready`, except under MODE=1 overwrite, where the head advances.

## Configuration
- `SIFIVE_SCOPE_TL_E_TIMESTAMP_EN`
  - Defined: the timestamp counter and per-entry TS_W storage are present, and behaviour is as above.
  - Undefined: no counter and no timestamp storage; `rd_ts` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, arm, then 3 fires with sink 1,0,1 on consecutive cycles starting 2 cycles after arm, then drain with `rd_ready`=1 -> entries (1,ts1),(0,ts2),(1,ts3); `count` 3->0; `rd_valid` drops after the third pop.
- MODE=0, DEPTH=4, 6 fires with no reads -> `done`=1 the cycle after the 4th fire; `count`=4; `drop_cnt`=0; drained entries are the first 4 sinks.
- MODE=1, DEPTH=4, 6 fires with sinks 0..5 and no reads -> `count`=4, `drop_cnt`=2, drained sinks 2,3,4,5; `capturing` stays 1.
- `arm` and `stop` in the same cycle from DONE with 3 entries -> next cycle `capturing`=1, `count`=0, `drop_cnt`=0.
- Full buffer (MODE=0 before final write) with fire and pop in the same cycle -> write accepted, `count` stays at DEPTH, no drop.
- `reset_n` asserted mid-capture with 5 entries -> immediately `count`=0, `rd_valid`=0, state IDLE; with the macro undefined, `rd_ts` reads 0 for all entries.

Source files
------------

// File: rtl/sifive_scope_tl_e_tracer.sv
//==============================================================================
// Module   : sifive_scope_tl_e_tracer
// Brief    : TileLink channel-E handshake tracer with circular capture buffer.
//            Optional timestamps: define SIFIVE_SCOPE_TL_E_TIMESTAMP_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sifive_scope_tl_e_tracer #(
  parameter int SINK_W = 1,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int MODE   = 0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       mon_valid,
  input  logic                       mon_ready,
  input  logic [SINK_W-1:0]          mon_sink,
  input  logic                       arm,
  input  logic                       stop,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [SINK_W-1:0]          rd_sink,
  output logic [TS_W-1:0]            rd_ts,
  output logic                       capturing,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 drop_cnt
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_CAPTURE = 2'd1;
  localparam logic [1:0] c_S_DONE    = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic [7:0]         r_drop;
  logic [SINK_W-1:0]  r_mem_sink [DEPTH];

  logic w_fire;
  logic w_pop;
  logic w_in_cap;
  logic w_full;
  logic w_wr;
  logic w_ovr;
  logic w_rd_adv;

  assign w_fire   = mon_valid & mon_ready;
  assign w_pop    = (r_count != '0) & rd_ready;
  assign w_in_cap = (r_state == c_S_CAPTURE);
  assign w_full   = (r_count == c_FULL);
  // A full one-shot buffer is never in CAPTURE, so only wrap mode writes when full without a pop.
  assign w_wr     = w_fire & w_in_cap & ~arm & (~w_full | w_pop | (MODE == 1));
  assign w_ovr    = w_wr & w_full & ~w_pop;
  assign w_rd_adv = w_pop | w_ovr;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_full)
      w_count_nxt = w_count_nxt + c_CNT_ONE;
    if (w_pop && !(w_wr && w_full))
      w_count_nxt = w_count_nxt - c_CNT_ONE;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_state <= c_S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic; arm takes priority over stop
  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = c_S_CAPTURE;
    end else begin
      case (r_state)
        c_S_CAPTURE: begin
          if (stop)
            w_state_nxt = c_S_DONE;
          else if ((MODE == 0) && w_wr && (w_count_nxt == c_FULL))
            w_state_nxt = c_S_DONE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    capturing = (r_state == c_S_CAPTURE);
    done      = (r_state == c_S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else if (arm) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_rd_adv)
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_count <= w_count_nxt;
      if (w_ovr && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem_sink[i] <= '0;
    end else if (w_wr) begin
      r_mem_sink[r_wr_ptr] <= mon_sink;
    end
  end

`ifdef SIFIVE_SCOPE_TL_E_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mem_ts [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_ts <= '0;
    else if (arm)
      r_ts <= '0;
    else if (w_in_cap)
      r_ts <= r_ts + TS_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem_ts[i] <= '0;
    end else if (w_wr) begin
      r_mem_ts[r_wr_ptr] <= r_ts;
    end
  end

  assign rd_ts = r_mem_ts[r_rd_ptr];
`else
  assign rd_ts = '0;
`endif

  assign rd_valid = (r_count != '0);
  assign rd_sink  = r_mem_sink[r_rd_ptr];
  assign count    = r_count;
  assign drop_cnt = r_drop;

endmodule

`default_nettype wire
